// File: rtl/ram_responder_pkg.sv
// Shared types for ram_responder: FSM state encoding, captured request
// record, wait-counter width and the address error rule.
package ram_responder_pkg;

    localparam int unsigned WS_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    // Misaligned, or word index beyond the 2**aw-word storage.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port synchronous word storage with byte write enables and a
// registered read port. Contents are never reset.
module ram_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_responder.sv
// Request/response RAM target: accepts one request in IDLE, waits
// WAIT_STATES cycles, performs the access and pulses a one-cycle response.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        err_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [WS_W-1:0]   cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [31:0]       data_q, data_d;

    logic [3:0]        ram_we;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_rdata;
    logic              acc_err;

    assign acc_err = addr_err(req_q.addr, AW);

    // The registered read port is pointed at the incoming address while idle
    // so the word is already latched by the access edge, even with zero waits.
    assign ram_addr = (state_q == ST_IDLE) ? addr_i[AW+1:2] : req_q.addr[AW+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        data_d  = data_q;
        ram_we  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    req_d   = '{we: we_i, addr: addr_i, data: data_i, be: be_i};
                    cnt_d   = WS_W'(WAIT_STATES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WS_W'(1);
                end else begin
                    state_d = ST_RESP;
                    valid_d = 1'b1;
                    err_d   = acc_err;
                    data_d  = (req_q.we || acc_err) ? '0 : ram_rdata;
                    if (req_q.we && !acc_err) begin
                        ram_we = req_q.be;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    ram_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (req_q.data),
        .rdata_o (ram_rdata)
    );

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign data_o  = data_q;

endmodule
